// File: rtl/rx_deframer_pkg.sv
// -----------------------------------------------------------------------------
// rx_deframer_pkg
// Shared constants for the receive-side packet deframer:
//   - K-code symbol values used for framing (idle comma, start, end)
//   - FSM state encodings for the deframer control path
//   - FIFO entry width ({last, data})
// No ports (package).
// -----------------------------------------------------------------------------
package rx_deframer_pkg;

  localparam logic [7:0] K_COMMA = 8'hBC;  // K28.5 idle
  localparam logic [7:0] K_STP   = 8'hFB;  // K27.7 start of packet
  localparam logic [7:0] K_END   = 8'hFD;  // K29.7 end of packet

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;

  localparam int ENTRY_W = 9;  // {last, data[7:0]}

endpackage

// File: rtl/rx_deframer_fifo.sv
// -----------------------------------------------------------------------------
// deframer_fifo
// Commit/rollback FIFO. Writes land at wrPtr but stay invisible to the reader
// until committed; a rollback rewinds wrPtr to the last commit point.
//
// Parameters:
//   DEPTH        entries, power of two, >= 4
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears all pointers)
//   enb          global enable; low freezes every pointer and the memory
//   i_wr_en      write i_wr_data at wrPtr and advance wrPtr
//   i_wr_data    {last, data}
//   i_commit     commitPtr <= wrPtr after this cycle's write
//   i_rollback   wrPtr <= commitPtr (discard uncommitted entries)
//   i_pop        advance rdPtr (ignored when no committed data)
//   o_rd_data    entry at rdPtr
//   o_full       wrPtr - rdPtr == DEPTH (uses pre-pop rdPtr)
//   o_empty      no committed, unread entries
//   o_committed  number of committed, unread entries
// -----------------------------------------------------------------------------
module deframer_fifo
  import rx_deframer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  logic                   i_wr_en,
  input  logic [ENTRY_W-1:0]     i_wr_data,
  input  logic                   i_commit,
  input  logic                   i_rollback,
  input  logic                   i_pop,
  output logic [ENTRY_W-1:0]     o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_committed
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_commit_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  logic [PW-1:0]      w_wr_next;

  // Commit point includes a write issued in the same cycle (END commits the
  // last byte on the edge that writes it).
  assign w_wr_next   = i_wr_en ? (r_wr_ptr + PW'(1)) : r_wr_ptr;

  // Same index bits with differing MSBs means the writer is a full lap ahead.
  assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty     = (r_commit_ptr == r_rd_ptr);
  assign o_committed = r_commit_ptr - r_rd_ptr;
  assign o_rd_data   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
    end else if (enb) begin
      if (i_rollback) begin
        r_wr_ptr <= r_commit_ptr;
      end else if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (i_commit) begin
        r_commit_ptr <= w_wr_next;
      end
      if (i_pop && !o_empty) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enb && i_wr_en && !i_rollback) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

endmodule

// File: rtl/rx_deframer.sv
// -----------------------------------------------------------------------------
// rx_deframer
// Packet deframer behind the receiver symbol decoder. Strips idle/STP/END
// framing, buffers payload in a commit/rollback FIFO and presents only
// complete, error-free packets as a valid/ready byte stream with a last flag.
//
// The newest payload byte is held in a staging register so that the END
// symbol can tag it with last=1 when it is written; every earlier byte is
// written with last=0 as its successor arrives.
//
// Optional feature: define DEFRAMER_STATS_EN to add saturating 16-bit
// goodCount/badCount outputs.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 4)
//   MAX_LEN   maximum payload bytes; longer packets are dropped
// Ports:
//   clk, rst           symbol clock, synchronous active-high reset
//   enb                global enable; low freezes all state and outputs
//   symValid           dataIn/kIn/errIn carry a symbol this cycle
//   dataIn, kIn, errIn decoded symbol, K flag, decode-error flag
//   dataOut, outLast   payload byte and end-of-packet marker
//   outValid, outReady byte handshake
//   pktGood, pktBad    one-cycle pulses: packet committed / discarded
//   goodCount, badCount  (DEFRAMER_STATS_EN only) packet counters
// -----------------------------------------------------------------------------
module rx_deframer
  import rx_deframer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic        symValid,
  input  logic [7:0]  dataIn,
  input  logic        kIn,
  input  logic        errIn,
  output logic [7:0]  dataOut,
  output logic        outValid,
  input  logic        outReady,
  output logic        outLast,
  output logic        pktGood,
  output logic        pktBad
`ifdef DEFRAMER_STATS_EN
  ,
  output logic [15:0] goodCount,
  output logic [15:0] badCount
`endif
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [7:0]         r_stage;
  logic               r_good;
  logic               r_bad;

  logic               w_sample;
  logic               w_is_stp;
  logic               w_is_end;
  logic [1:0]         w_state_nxt;
  logic [CW-1:0]      w_count_nxt;
  logic               w_stage_ld;
  logic               w_wr_en;
  logic               w_wr_last;
  logic               w_commit;
  logic               w_rollback;
  logic               w_good;
  logic               w_bad;
  logic               w_drop;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [PW-1:0]      w_committed;
  logic [ENTRY_W-1:0] w_rd_data;

  assign w_sample = enb & symValid;
  assign w_is_stp = kIn & (dataIn == K_STP) & ~errIn;
  assign w_is_end = kIn & (dataIn == K_END) & ~errIn;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_stage_ld  = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_last   = 1'b0;
    w_commit    = 1'b0;
    w_rollback  = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    w_drop      = 1'b0;
    if (w_sample) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_stp) begin
            w_state_nxt = ST_PAYLOAD;
            w_count_nxt = '0;
          end
        end
        ST_PAYLOAD: begin
          if (errIn) begin
            w_drop = 1'b1;
          end else if (!kIn) begin
            // A staged byte must be flushed to make room, so fullness only
            // matters once something is staged.
            if ((r_count == MAX_CNT) || ((r_count != '0) && w_full)) begin
              w_drop = 1'b1;
            end else begin
              w_wr_en     = (r_count != '0);
              w_stage_ld  = 1'b1;
              w_count_nxt = r_count + CW'(1);
            end
          end else if (dataIn == K_END) begin
            if (r_count == '0) begin
              w_bad       = 1'b1;
              w_state_nxt = ST_IDLE;
            end else if (w_full) begin
              w_drop = 1'b1;
            end else begin
              w_wr_en     = 1'b1;
              w_wr_last   = 1'b1;
              w_commit    = 1'b1;
              w_good      = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else if (dataIn == K_STP) begin
            // Restart: abandon the current packet but stay in PAYLOAD.
            w_rollback  = 1'b1;
            w_bad       = 1'b1;
            w_count_nxt = '0;
          end else if (dataIn != K_COMMA) begin
            w_drop = 1'b1;
          end
        end
        ST_DROP: begin
          if (w_is_end) begin
            w_state_nxt = ST_IDLE;
          end else if (w_is_stp) begin
            w_state_nxt = ST_PAYLOAD;
            w_count_nxt = '0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    if (w_drop) begin
      w_rollback  = 1'b1;
      w_bad       = 1'b1;
      w_state_nxt = ST_DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_good  <= 1'b0;
      r_bad   <= 1'b0;
    end else if (enb) begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_good  <= w_good;
      r_bad   <= w_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (enb && w_stage_ld) begin
      r_stage <= dataIn;
    end
  end

  assign w_pop = enb & outReady & ~w_empty;

  deframer_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .i_wr_en    (w_wr_en),
    .i_wr_data  ({w_wr_last, r_stage}),
    .i_commit   (w_commit),
    .i_rollback (w_rollback),
    .i_pop      (w_pop),
    .o_rd_data  (w_rd_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_committed(w_committed)
  );

  // Memory is not reset, so the byte lanes are forced to zero while nothing
  // committed is visible.
  assign outValid = (w_committed != '0);
  assign dataOut  = outValid ? w_rd_data[7:0] : 8'h00;
  assign outLast  = outValid & w_rd_data[8];
  assign pktGood  = r_good;
  assign pktBad   = r_bad;

`ifdef DEFRAMER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      goodCount <= '0;
      badCount  <= '0;
    end else if (enb) begin
      if (w_good && (goodCount != 16'hFFFF)) begin
        goodCount <= goodCount + 16'd1;
      end
      if (w_bad && (badCount != 16'hFFFF)) begin
        badCount <= badCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_rx_deframer
// Scoreboard bench for rx_deframer (DEPTH=4, MAX_LEN=4). The stimulus process
// runs a packet-level reference model and queues expected per-cycle status and
// expected output bytes; an independent monitor compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_rx_deframer;

  localparam int DEPTH   = 4;
  localparam int MAX_LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic       symValid = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       kIn = 1'b0;
  logic       errIn = 1'b0;
  logic       outReady = 1'b0;
  logic [7:0] dataOut;
  logic       outValid;
  logic       outLast;
  logic       pktGood;
  logic       pktBad;
`ifdef DEFRAMER_STATS_EN
  logic [15:0] goodCount;
  logic [15:0] badCount;
`endif

  rx_deframer #(
    .DEPTH  (DEPTH),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .symValid (symValid),
    .dataIn   (dataIn),
    .kIn      (kIn),
    .errIn    (errIn),
    .dataOut  (dataOut),
    .outValid (outValid),
    .outReady (outReady),
    .outLast  (outLast),
    .pktGood  (pktGood),
    .pktBad   (pktBad)
`ifdef DEFRAMER_STATS_EN
    ,
    .goodCount(goodCount),
    .badCount (badCount)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tag;
    bit outv;
    bit good;
    bit bad;
    bit zero;
  } exp_t;

  exp_t       exq[$];
  logic [8:0] sb[$];
  int         errors = 0;
  int         checks = 0;

  // Reference model state (packet level)
  int         m_mode;   // 0 outside packet, 1 collecting, 2 discarding
  logic [7:0] m_cur[$]; // bytes of the packet being collected
  int         m_avail;  // committed, unread bytes
  bit         m_good, m_bad;
  int         n_good, n_bad;
  bit         g_en, g_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: per-cycle status and byte handshakes.
  exp_t       mon_x;
  logic [8:0] mon_b;
  always @(negedge clk) begin
    if (exq.size() > 0 && exq[0].tag == cyc) begin
      mon_x = exq.pop_front();
      chk("outValid", {31'd0, outValid}, {31'd0, mon_x.outv});
      chk("pktGood", {31'd0, pktGood}, {31'd0, mon_x.good});
      chk("pktBad", {31'd0, pktBad}, {31'd0, mon_x.bad});
      if (mon_x.zero) begin
        chk("reset_dataOut", {24'd0, dataOut}, 32'd0);
        chk("reset_outLast", {31'd0, outLast}, 32'd0);
      end
    end
    if (rst === 1'b0 && enb === 1'b1 && outReady === 1'b1 && outValid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h, expected no byte (cycle %0d)", {outLast, dataOut}, cyc);
      end else begin
        mon_b = sb.pop_front();
        chk("byte", {23'd0, outLast, dataOut}, {23'd0, mon_b});
      end
    end
  end

  task automatic push_exp(input bit zero);
    exp_t x;
    x.tag  = cyc + 1;
    x.outv = (m_avail > 0);
    x.good = m_good;
    x.bad  = m_bad;
    x.zero = zero;
    exq.push_back(x);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; enb = 1'b1; symValid = 1'b0; outReady = g_rdy;
    m_mode = 0; m_cur.delete(); m_avail = 0; m_good = 0; m_bad = 0;
    n_good = 0; n_bad = 0;
    sb.delete();
    push_exp(1'b1);
  endtask

  task automatic discard_cur();
    m_cur.delete();
    m_mode = 2;
    m_bad = 1;
  endtask

  // One symbol cycle; the model works out what the next edge must produce.
  task automatic step(input bit sv, input logic [7:0] d, input bit k, input bit e);
    int  in_fifo;
    bit  pop;
    @(posedge clk);
    #1;
    rst = 1'b0; enb = g_en; outReady = g_rdy;
    symValid = sv; dataIn = d; kIn = k; errIn = e;
    pop = g_en && g_rdy && (m_avail > 0);
    // bytes of the current packet already in the FIFO (all but the newest)
    in_fifo = (m_cur.size() > 0) ? m_cur.size() - 1 : 0;
    if (g_en) begin
      m_good = 0;
      m_bad  = 0;
      if (sv) begin
        if (m_mode == 0) begin
          if (k && d == 8'hFB && !e) begin m_mode = 1; m_cur.delete(); end
        end else if (m_mode == 2) begin
          if (k && d == 8'hFD && !e) m_mode = 0;
          else if (k && d == 8'hFB && !e) begin m_mode = 1; m_cur.delete(); end
        end else begin
          if (e) discard_cur();
          else if (!k) begin
            if (m_cur.size() == MAX_LEN) discard_cur();
            else if (m_cur.size() >= 1 && m_avail + in_fifo >= DEPTH) discard_cur();
            else m_cur.push_back(d);
          end else if (d == 8'hFD) begin
            if (m_cur.size() == 0) begin m_bad = 1; m_mode = 0; end
            else if (m_avail + in_fifo >= DEPTH) discard_cur();
            else begin
              for (int i = 0; i < m_cur.size(); i++)
                sb.push_back({(i == m_cur.size() - 1), m_cur[i]});
              m_avail += m_cur.size();
              m_cur.delete();
              m_good = 1;
              m_mode = 0;
            end
          end else if (d == 8'hFB) begin
            m_cur.delete(); m_bad = 1;
          end else if (d != 8'hBC) discard_cur();
        end
      end
      if (m_good) n_good++;
      if (m_bad) n_bad++;
    end
    if (pop) m_avail--;
    push_exp(1'b0);
  endtask

  task automatic dat(input logic [7:0] d); step(1, d, 0, 0); endtask
  task automatic kc(input logic [7:0] d); step(1, d, 1, 0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0); endtask

  logic [7:0] otherk[4] = '{8'h1C, 8'h3C, 8'hF7, 8'hFC};

  initial begin
    int r;
    g_en = 1; g_rdy = 1;
    do_reset();
    do_reset();

    // Basic packet with leading idle comma
    kc(8'hBC); kc(8'hFB); dat(8'h11); dat(8'h22); dat(8'h33); kc(8'hFD);
    idle(5);

    // Errored packet, then a clean single-byte packet
    kc(8'hFB); dat(8'h11); step(1, 8'h22, 0, 1); dat(8'h33); kc(8'hFD);
    kc(8'hFB); dat(8'h44); kc(8'hFD);
    idle(4);

    // Empty packet
    kc(8'hFB); kc(8'hFD);
    idle(3);

    // Over-length packet
    kc(8'hFB); dat(8'h01); dat(8'h02); dat(8'h03); dat(8'h04); dat(8'h05); kc(8'hFD);
    idle(3);

    // FIFO full drop with output stalled
    g_rdy = 0;
    kc(8'hFB); dat(8'hA1); dat(8'hA2); dat(8'hA3); kc(8'hFD);
    kc(8'hFB); dat(8'hB1); dat(8'hB2); dat(8'hB3); kc(8'hFD);
    idle(2);
    g_rdy = 1;
    idle(6);

    // Reset with committed bytes still unread, then a fresh packet
    g_rdy = 0;
    kc(8'hFB); dat(8'h66); dat(8'h77); kc(8'hFD);
    kc(8'hFB); dat(8'h88);
    do_reset();
    g_rdy = 1;
    kc(8'hFB); dat(8'h55); kc(8'hFD);
    idle(4);

    // Enable low freezes everything, including a held pulse
    kc(8'hFB); dat(8'h9A);
    g_rdy = 1; kc(8'hFD);
    g_en = 0; dat(8'h12); kc(8'hFD); idle(1);
    g_en = 1; idle(3);

    // Randomized symbol stream
    for (int n = 0; n < 2000; n++) begin
      g_en  = ($urandom_range(0, 9) != 0);
      g_rdy = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 9)       kc(8'hFB);
      else if (r < 17) kc(8'hFD);
      else if (r < 21) kc(8'hBC);
      else if (r < 23) kc(otherk[$urandom_range(0, 3)]);
      else if (r < 25) step(1, 8'($urandom), 0, 1);
      else if (r < 30) step(0, 8'($urandom), 0, 0);
      else             dat(8'($urandom));
    end

    // Drain
    g_en = 1; g_rdy = 1;
    idle(12);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain_scoreboard_empty", sb.size(), 0);
    chk("drain_status_queue_empty", exq.size(), 0);
`ifdef DEFRAMER_STATS_EN
    chk("goodCount", {16'd0, goodCount}, n_good);
    chk("badCount", {16'd0, badCount}, n_bad);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
